// File: rtl/rd_responder.sv
// Read responder: 8x8 register file returned over a rd/ws/dvalid handshake with WAIT_CYC wait states.
// Define RD_RESPONDER_PARITY_EN to add the dpar_o even-parity output.
module rd_responder #(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rd_i,
    input  logic [2:0] addr_i,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    output logic       ws_o,
    output logic [7:0] dout_o,
    output logic       dvalid_o,
    output logic       err_o
`ifdef RD_RESPONDER_PARITY_EN
    ,
    output logic       dpar_o
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StData} state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_CYC);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  mem_q [8];
    logic [7:0]  mem_d [8];
    logic        ws_q, ws_d;
    logic        dvalid_q, dvalid_d;
    logic [7:0]  dout_q, dout_d;
    logic        err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        mem_d    = mem_q;
        ws_d     = ws_q;
        dvalid_d = 1'b0;
        dout_d   = 8'h00;
        err_d    = err_q;
        unique case (state_q)
            StIdle, StData: begin
                // A request in the data cycle chains straight into the next read.
                if (rd_i) begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                    addr_d  = addr_i;
                    ws_d    = 1'b1;
                end else begin
                    state_d = StIdle;
                    ws_d    = 1'b0;
                end
                if (wr_i) begin
                    if (rd_i || (state_q == StData)) begin
                        err_d = 1'b1;
                    end else begin
                        mem_d[addr_i] = wdata_i;
                    end
                end
            end
            StWait: begin
                if (rd_i || wr_i) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d  = StData;
                    ws_d     = 1'b0;
                    dvalid_d = 1'b1;
                    dout_d   = mem_q[addr_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                ws_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= 3'd0;
            ws_q     <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= 8'h00;
            err_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 8'(i) * 8'h11;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            ws_q     <= ws_d;
            dvalid_q <= dvalid_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

    assign ws_o     = ws_q;
    assign dvalid_o = dvalid_q;
    assign dout_o   = dout_q;
    assign err_o    = err_q;

`ifdef RD_RESPONDER_PARITY_EN
    logic dpar_q;

    // dout_d is already zero outside the data cycle, so its parity is qualified for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dpar_q <= 1'b0;
        end else begin
            dpar_q <= ^dout_d;
        end
    end

    assign dpar_o = dpar_q;
`endif

endmodule

// File: tb/tb_rd_responder.sv
// Randomised bench for rd_responder: two instances (WAIT_CYC=2 and 0) checked against a
// transaction-level model built from countdowns and a word array.
module tb_rd_responder;

    localparam int NI = 2;
    localparam int WC [NI] = '{2, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd, wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       ws [NI];
    logic       dvalid [NI];
    logic       err [NI];
    logic [7:0] dout [NI];
`ifdef RD_RESPONDER_PARITY_EN
    logic       dpar [NI];
`endif

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    rd_responder #(.WAIT_CYC(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .rd_i(rd), .addr_i(addr), .wr_i(wr), .wdata_i(wdata),
        .ws_o(ws[0]), .dout_o(dout[0]), .dvalid_o(dvalid[0]), .err_o(err[0])
`ifdef RD_RESPONDER_PARITY_EN
        , .dpar_o(dpar[0])
`endif
    );

    rd_responder #(.WAIT_CYC(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .rd_i(rd), .addr_i(addr), .wr_i(wr), .wdata_i(wdata),
        .ws_o(ws[1]), .dout_o(dout[1]), .dvalid_o(dvalid[1]), .err_o(err[1])
`ifdef RD_RESPONDER_PARITY_EN
        , .dpar_o(dpar[1])
`endif
    );

    // Reference state: an outstanding read is just a countdown plus the word it will return.
    bit         m_busy [NI];
    int         m_rem [NI];
    logic [7:0] m_rdata [NI];
    bit         m_dv [NI];
    logic [7:0] m_dout [NI];
    bit         m_err [NI];
    logic [7:0] m_mem [NI][8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0;
            m_rem[i]  = 0;
            m_dv[i]   = 1'b0;
            m_dout[i] = 8'h00;
            m_err[i]  = 1'b0;
            for (int j = 0; j < 8; j++) m_mem[i][j] = 8'(j * 17);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (m_busy[i]) begin
                if (rd || wr) m_err[i] = 1'b1;
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_busy[i] = 1'b0;
                    m_dv[i]   = 1'b1;
                    m_dout[i] = m_rdata[i];
                end else begin
                    m_dv[i]   = 1'b0;
                    m_dout[i] = 8'h00;
                end
            end else begin
                if (wr) begin
                    if (rd || m_dv[i]) m_err[i] = 1'b1;
                    else m_mem[i][addr] = wdata;
                end
                if (rd) begin
                    m_busy[i]  = 1'b1;
                    m_rem[i]   = WC[i] + 1;
                    m_rdata[i] = m_mem[i][addr];
                end
                m_dv[i]   = 1'b0;
                m_dout[i] = 8'h00;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s_ws%0d", tag, i), 32'(ws[i]), 32'(m_busy[i]));
            check_eq($sformatf("%s_dvalid%0d", tag, i), 32'(dvalid[i]), 32'(m_dv[i]));
            check_eq($sformatf("%s_dout%0d", tag, i), 32'(dout[i]), 32'(m_dout[i]));
            check_eq($sformatf("%s_err%0d", tag, i), 32'(err[i]), 32'(m_err[i]));
`ifdef RD_RESPONDER_PARITY_EN
            check_eq($sformatf("%s_dpar%0d", tag, i), 32'(dpar[i]), 32'(^m_dout[i]));
`endif
        end
    endtask

    task automatic step(input string tag, input logic r, input logic w, input logic [2:0] a,
                        input logic [7:0] d);
        @(negedge clk);
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 3'd0;
        wdata = 8'h00;
        #3;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("rd3", 1'b1, 1'b0, 3'd3, 8'h00);
        idle("rd3_wait", 4);

        step("wr5", 1'b0, 1'b1, 3'd5, 8'hA5);
        step("rd5", 1'b1, 1'b0, 3'd5, 8'h00);
        idle("rd5_wait", 4);

        step("rd1", 1'b1, 1'b0, 3'd1, 8'h00);
        step("rd1_again", 1'b1, 1'b0, 3'd1, 8'h00);
        idle("rd1_wait", 5);

        reset_pulse("rst_b2b");
        step("rd2", 1'b1, 1'b0, 3'd2, 8'h00);
        idle("rd2_wait", 3);
        step("rd6_chain", 1'b1, 1'b0, 3'd6, 8'h00);
        idle("rd6_wait", 5);

        step("rd4", 1'b1, 1'b0, 3'd4, 8'h00);
        step("rd4_w", 1'b0, 1'b0, 3'd0, 8'h00);
        reset_pulse("rst_mid");
        idle("post_rst", 5);
        step("rd5_rst", 1'b1, 1'b0, 3'd5, 8'h00);
        idle("rd5_rst_wait", 4);
        step("rd7", 1'b1, 1'b0, 3'd7, 8'h00);
        idle("rd7_wait", 4);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset_pulse("rand_rst");
            end else begin
                step("rand", 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 3),
                     3'($urandom_range(0, 7)), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
